ahb_arb_2m: RTL

AHB_ARB_2M -- requirements
Module: ahb_arb_2m

---
 rtl/ahb_arb_2m.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ahb_arb_2m.sv
// ---------------------------------------------------------------------------
// ahb_arb_2m -- two-master AHB bus arbiter
//
// Purpose:
//   Grants the AHB bus to one of two masters. The grant moves only at
//   arbitration points. These are HREADY cycles that end an IDLE, a fixed
//   burst, a SINGLE transfer or a NONSEQ beat of an undefined-length (INCR)
//   burst. Arbitration is round-robin between requesters. A locked owner
//   keeps the bus, and the bus parks on DEFAULT_MASTER when nobody asks.
//   HMASTER and HMASTLOCK follow the grant one HREADY-qualified cycle later.
//   This matches the address phase of the newly granted master.
//
// Parameters:
//   DEFAULT_MASTER  parking master index (0 or 1)
//
// Ports:
//   i_hclk       in   1  bus clock, rising edge
//   i_hresetn    in   1  asynchronous active-low reset
//   i_hbusreq    in   2  bus request, bit n from master n
//   i_hlock      in   2  locked-transfer request, bit n from master n
//   i_htrans     in   2  HTRANS of the current bus owner
//   i_hburst     in   3  HBURST of the current bus owner
//   i_hready     in   1  bus HREADY
//   o_hgrant     out  2  one-hot grant (always exactly one bit set)
//   o_hmaster    out  1  master owning the current address phase
//   o_hmastlock  out  1  current address phase belongs to a locked sequence
// ---------------------------------------------------------------------------
module ahb_arb_2m #(
   parameter int unsigned DEFAULT_MASTER = 0
) (
   input  logic       i_hclk,
   input  logic       i_hresetn,
   input  logic [1:0] i_hbusreq,
   input  logic [1:0] i_hlock,
   input  logic [1:0] i_htrans,
   input  logic [2:0] i_hburst,
   input  logic       i_hready,
   output logic [1:0] o_hgrant,
   output logic       o_hmaster,
   output logic       o_hmastlock
);

   // Parking index as a 1-bit value; any non-zero parameter means master 1.
   localparam logic DEF_IDX = (DEFAULT_MASTER != 0) ? 1'b1 : 1'b0;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HBURST_INCR   = 3'b001;

   localparam logic [4:0] CNT_MAX       = 5'd31;

   // Beat count of a fixed-length burst. INCR has no defined length and maps
   // to 0, which no beat number can ever equal.
   function automatic logic [4:0] burst_len(input logic [2:0] hburst);
      logic [4:0] len;
      case (hburst)
         3'b000:         len = 5'd1;
         3'b010, 3'b011: len = 5'd4;
         3'b100, 3'b101: len = 5'd8;
         3'b110, 3'b111: len = 5'd16;
         default:        len = 5'd0;
      endcase
      return len;
   endfunction

   // ---------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------
   logic       grant_idx_r;   // currently granted master
   logic       hmaster_r;     // owner of the current address phase
   logic       hmastlock_r;   // lock qualifier of the current address phase
   logic       prio_r;        // master holding round-robin priority
   logic [4:0] beat_cnt_r;    // accepted beats in the current burst
   logic       first_r;       // first HREADY cycle after reset release

   // ---------------------------------------------------------------------
   // Decision signals
   // ---------------------------------------------------------------------
   logic       accept_s;      // a NONSEQ/SEQ beat completes this cycle
   logic [4:0] beat_num_s;    // number of the beat on the bus now
   logic       last_beat_s;   // that beat closes a fixed-length burst
   logic       incr_end_s;    // INCR burst may be cut at a NONSEQ beat
   logic       arb_pt_s;      // grant may move at the coming edge
   logic       locked_s;      // owner keeps the bus through a lock
   logic       next_idx_s;    // master chosen for the next grant
   logic       change_s;      // grant moves at the coming edge

   // Classify the current bus cycle and find out whether it is an arbitration point.
   always_comb begin
      accept_s    = 1'b0;
      beat_num_s  = 5'd0;
      last_beat_s = 1'b0;
      incr_end_s  = 1'b0;
      arb_pt_s    = 1'b0;

      accept_s = i_hready && ((i_htrans == HTRANS_NONSEQ) || (i_htrans == HTRANS_SEQ));

      // NONSEQ always opens beat 1; SEQ continues from the count. The count
      // saturates so that a long INCR burst cannot wrap.
      if (i_htrans == HTRANS_NONSEQ) begin
         beat_num_s = 5'd1;
      end else if (beat_cnt_r == CNT_MAX) begin
         beat_num_s = CNT_MAX;
      end else begin
         beat_num_s = beat_cnt_r + 5'd1;
      end

      // A SINGLE NONSEQ beat is beat 1 of a length-1 burst, so it also counts
      // as a last beat. INCR maps to length 0 and never matches.
      last_beat_s = accept_s && (beat_num_s == burst_len(i_hburst));

      incr_end_s  = (i_hburst == HBURST_INCR) && (i_htrans == HTRANS_NONSEQ);

      // A BUSY beat never meets any of the terms below, so the grant never
      // moves during BUSY.
      arb_pt_s = i_hready &&
                 (first_r || (i_htrans == HTRANS_IDLE) || last_beat_s || incr_end_s);
   end

   // Choose the next owner: lock first, then round-robin, then park.
   always_comb begin
      locked_s   = 1'b0;
      next_idx_s = grant_idx_r;
      change_s   = 1'b0;

      locked_s = i_hlock[grant_idx_r] && i_hbusreq[grant_idx_r];

      if (locked_s) begin
         next_idx_s = grant_idx_r;
      end else begin
         case (i_hbusreq)
            2'b00:   next_idx_s = DEF_IDX;
            2'b01:   next_idx_s = 1'b0;
            2'b10:   next_idx_s = 1'b1;
            2'b11:   next_idx_s = prio_r;
            default: next_idx_s = grant_idx_r;
         endcase
      end

      change_s = arb_pt_s && (next_idx_s != grant_idx_r);
   end

   // Grant, priority, beat counter and address-phase ownership registers.
   always_ff @(posedge i_hclk or negedge i_hresetn) begin
      if (!i_hresetn) begin
         grant_idx_r <= DEF_IDX;
         hmaster_r   <= DEF_IDX;
         hmastlock_r <= 1'b0;
         prio_r      <= ~DEF_IDX;
         beat_cnt_r  <= 5'd0;
         first_r     <= 1'b1;
      end else begin
         // The loser of a grant change gets priority for the next contest.
         // A new owner starts counting its burst from zero.
         if (change_s) begin
            grant_idx_r <= next_idx_s;
            prio_r      <= ~next_idx_s;
            beat_cnt_r  <= 5'd0;
         end else if (accept_s) begin
            grant_idx_r <= grant_idx_r;
            prio_r      <= prio_r;
            if (i_htrans == HTRANS_NONSEQ) begin
               beat_cnt_r <= 5'd1;
            end else if (beat_cnt_r == CNT_MAX) begin
               beat_cnt_r <= CNT_MAX;
            end else begin
               beat_cnt_r <= beat_cnt_r + 5'd1;
            end
         end else begin
            grant_idx_r <= grant_idx_r;
            prio_r      <= prio_r;
            beat_cnt_r  <= beat_cnt_r;
         end

         // Ownership follows the grant that was already on the bus at this
         // HREADY edge. This makes it lag the grant by one accepted cycle and
         // hold through wait states.
         if (i_hready) begin
            hmaster_r   <= grant_idx_r;
            hmastlock_r <= i_hlock[grant_idx_r];
            first_r     <= 1'b0;
         end else begin
            hmaster_r   <= hmaster_r;
            hmastlock_r <= hmastlock_r;
            first_r     <= first_r;
         end
      end
   end

   // The outputs come straight from registers. The grant index is decoded
   // to one-hot, so exactly one bit is always set.
   assign o_hgrant    = grant_idx_r ? 2'b10 : 2'b01;
   assign o_hmaster   = hmaster_r;
   assign o_hmastlock = hmastlock_r;

   // HTRANS_BUSY is named only for readability of the transfer encoding.
   logic unused_busy_s;
   assign unused_busy_s = (HTRANS_BUSY == 2'b01);

endmodule
